// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit path.
//   - arb_state_t     : state encoding of the TX write-port arbiter
//   - UART_DATA_WIDTH : default byte width, shared with the TX FIFO
//   - UART_FIFO_DEPTH : default TX FIFO entry count (FIFO CHARACTER_COUNT)
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // waiting for a requester, no byte accepted here
      SEND = 2'd1,   // streaming the granted source's message
      GAP  = 2'd2    // inter-message idle time
   } arb_state_t;

   localparam int UART_DATA_WIDTH = 8;
   localparam int UART_FIFO_DEPTH = 10;

endpackage

// File: rtl/uart_rr_picker.sv
// -----------------------------------------------------------------------------
// uart_rr_picker
//   Combinational round-robin pick. Searches req starting at
//   (last_grant + 1) mod NUM_REQ, wrapping, and returns the first set bit.
//   Ports:
//     req        in  NUM_REQ  pending requests
//     last_grant in  IDX_W    most recently granted index
//     grant      out IDX_W    winning index (last_grant when nothing pending)
//     any        out 1        at least one request pending
// -----------------------------------------------------------------------------
module uart_rr_picker
   import uart_pkg::*;
#(
   parameter  int NUM_REQ = 3,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [IDX_W-1:0]   grant,
   output logic               any
);

   always_comb begin
      int   idx;
      logic found;
      // NOTE: every output and temporary gets a default before any branch, so
      // no path leaves a value unassigned and no latch is inferred.
      grant = last_grant;
      any   = |req;
      found = 1'b0;
      idx   = 0;
      // Offsets 1..NUM_REQ: the previous winner is examined last.
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_grant) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            grant = IDX_W'(idx);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares the single UART TX FIFO write port between NUM_REQ message sources.
//   Grants whole messages round-robin, so messages never interleave in the
//   FIFO, and tracks FIFO occupancy with a credit counter so it never writes
//   into a full FIFO (the FIFO would silently shift out old data).
//   Ports:
//     clk, reset_n   clock, asynchronous active-low reset
//     ena            global enable; 0 freezes every register
//     req_valid      per-source byte valid
//     req_data       per-source byte, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_last       per-source end-of-message marker
//     req_ready      per-source accept (combinational from state and level)
//     fifo_wr_data   registered byte to the FIFO
//     fifo_wr_valid  registered one-cycle write strobe to the FIFO
//     fifo_rd_pulse  one pulse per byte drained by the FIFO
//     grant_id       current or last granted source
//     busy           high in SEND or GAP
//     fifo_level     credit-counter occupancy
//     abort          one-cycle pulse when a stalled message is abandoned
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int NUM_REQ        = 3,
   parameter  int DATA_WIDTH     = UART_DATA_WIDTH,
   parameter  int FIFO_DEPTH     = UART_FIFO_DEPTH,
   parameter  int GAP_CYCLES     = 0,
   parameter  int TIMEOUT_CYCLES = 255,
   localparam int ID_W           = $clog2(NUM_REQ),
   localparam int LVL_W          = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          ena,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic                          fifo_wr_valid,
   input  logic                          fifo_rd_pulse,
   output logic [ID_W-1:0]               grant_id,
   output logic                          busy,
   output logic [LVL_W-1:0]              fifo_level,
   output logic                          abort
);

   localparam int GAP_W    = (GAP_CYCLES > 1)     ? $clog2(GAP_CYCLES + 1)     : 1;
   localparam int TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int GAP_LAST = (GAP_CYCLES > 0)     ? GAP_CYCLES - 1             : 0;
   localparam int TO_LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1         : 0;

   arb_state_t              state_q, state_d;
   logic [ID_W-1:0]         grant_q, grant_d;
   logic [LVL_W-1:0]        level_q, level_d;
   logic [GAP_W-1:0]        gap_q, gap_d;
   logic [TO_W-1:0]         to_q, to_d;
   logic                    abort_q, abort_d;
   logic                    wr_valid_q;
   logic [DATA_WIDTH-1:0]   wr_data_q;

   logic [ID_W-1:0]         pick_id;
   logic                    pick_any;
   logic                    sel_valid, sel_last, has_room, accept, rd_eff;
   logic [DATA_WIDTH-1:0]   sel_data;

   uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req        (req_valid),
      .last_grant (grant_q),
      .grant      (pick_id),
      .any        (pick_any)
   );

   // Granted source's beat.
   assign sel_valid = req_valid[grant_q];
   assign sel_last  = req_last[grant_q];
   assign sel_data  = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];

   assign has_room  = (level_q < LVL_W'(FIFO_DEPTH));
   assign accept    = ena && (state_q == SEND) && has_room && sel_valid;
   // The FIFO is frozen with us, so its read strobe means nothing while ena=0.
   assign rd_eff    = ena && fifo_rd_pulse;

   always_comb begin
      req_ready = '0;
      if ((state_q == SEND) && ena && has_room) req_ready[grant_q] = 1'b1;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gap_d   = gap_q;
      to_d    = to_q;
      abort_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d = pick_id;
               state_d = SEND;
               to_d    = '0;
            end
         end
         SEND: begin
            if (accept) begin
               to_d = '0;
               if (sel_last) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            end else if (TIMEOUT_CYCLES > 0) begin
               // Any stall counts, including one caused by a full FIFO.
               // grant_id is left on the aborted source so the next pick
               // starts after it.
               if (to_q == TO_W'(TO_LAST)) begin
                  abort_d = 1'b1;
                  state_d = IDLE;
                  to_d    = '0;
               end else begin
                  to_d = to_q + 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_q == GAP_W'(GAP_LAST)) begin
               gap_d   = '0;
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Credit counter: counted at acceptance (ahead of the actual write) so it
   // never under-reports occupancy. A simultaneous drain cancels the accept.
   always_comb begin
      level_d = level_q;
      if (accept && !rd_eff)                       level_d = level_q + 1'b1;
      else if (!accept && rd_eff && level_q != '0) level_d = level_q - 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // register samples pre-edge values regardless of statement order.
         state_q    <= IDLE;
         grant_q    <= ID_W'(NUM_REQ - 1);   // source 0 wins first
         level_q    <= '0;
         gap_q      <= '0;
         to_q       <= '0;
         abort_q    <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_data_q  <= '0;
      end else if (ena) begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         level_q    <= level_d;
         gap_q      <= gap_d;
         to_q       <= to_d;
         abort_q    <= abort_d;
         wr_valid_q <= accept;
         if (accept) wr_data_q <= sel_data;
      end
   end

   // Strobes are masked while frozen; a held strobe fires once ena returns,
   // so a byte accepted just before a freeze still reaches the FIFO.
   assign fifo_wr_valid = wr_valid_q && ena;
   assign fifo_wr_data  = wr_data_q;
   assign abort         = abort_q && ena;
   assign grant_id      = grant_q;
   assign busy          = (state_q != IDLE);
   assign fifo_level    = level_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Two instances share stimulus: dut_a (no gap, 4-cycle timeout) and dut_b
//   (3-cycle gap, timeout disabled). Outputs of the selected instance are
//   checked against a message-level model: expected FIFO byte order from
//   round-robin over whole messages, and occupancy from accept/drain counts.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int NR    = 3;
   localparam int DW    = 8;
   localparam int DEPTH = 10;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic             clk = 1'b0;
   logic             reset_n, ena, fifo_rd_pulse;
   logic [NR-1:0]    req_valid, req_last;
   logic [NR*DW-1:0] req_data;

   logic [NR-1:0] a_ready, b_ready, o_ready;
   logic [DW-1:0] a_wr_data, b_wr_data, o_wr_data;
   logic          a_wr_valid, b_wr_valid, o_wr_valid;
   logic [1:0]    a_grant, b_grant, o_grant;
   logic          a_busy, b_busy, o_busy;
   logic [3:0]    a_level, b_level, o_level;
   logic          a_abort, b_abort, o_abort;
   logic          use_b = 1'b0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
                     .GAP_CYCLES(0), .TIMEOUT_CYCLES(4)) dut_a (
      .clk(clk), .reset_n(reset_n), .ena(ena), .req_valid(req_valid),
      .req_data(req_data), .req_last(req_last), .req_ready(a_ready),
      .fifo_wr_data(a_wr_data), .fifo_wr_valid(a_wr_valid),
      .fifo_rd_pulse(fifo_rd_pulse), .grant_id(a_grant), .busy(a_busy),
      .fifo_level(a_level), .abort(a_abort));

   uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
                     .GAP_CYCLES(3), .TIMEOUT_CYCLES(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .ena(ena), .req_valid(req_valid),
      .req_data(req_data), .req_last(req_last), .req_ready(b_ready),
      .fifo_wr_data(b_wr_data), .fifo_wr_valid(b_wr_valid),
      .fifo_rd_pulse(fifo_rd_pulse), .grant_id(b_grant), .busy(b_busy),
      .fifo_level(b_level), .abort(b_abort));

   assign o_ready    = use_b ? b_ready    : a_ready;
   assign o_wr_data  = use_b ? b_wr_data  : a_wr_data;
   assign o_wr_valid = use_b ? b_wr_valid : a_wr_valid;
   assign o_grant    = use_b ? b_grant    : a_grant;
   assign o_busy     = use_b ? b_busy     : a_busy;
   assign o_level    = use_b ? b_level    : a_level;
   assign o_abort    = use_b ? b_abort    : a_abort;

   int vectors     = 0;
   int miscompares = 0;

   // Model state
   beat_t         srcq [NR][$];   // beats each source still has to offer
   logic [DW-1:0] exp_stream[$];  // bytes the FIFO must receive, in order
   int            lvl_m;
   logic          wr_pend;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; ena = 1'b0; fifo_rd_pulse = 1'b0;
      req_valid = '0; req_last = '0; req_data = '0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      lvl_m = 0; wr_pend = 1'b0;
      exp_stream.delete();
      for (int s = 0; s < NR; s++) srcq[s].delete();
   endtask

   task automatic add_beat(input int s, input logic [DW-1:0] d, input logic last);
      srcq[s].push_back('{data: d, last: last});
   endtask

   task automatic drive_srcs();
      for (int s = 0; s < NR; s++) begin
         if (srcq[s].size() > 0) begin
            req_valid[s]           = 1'b1;
            req_data[s*DW +: DW]   = srcq[s][0].data;
            req_last[s]            = srcq[s][0].last;
         end else begin
            req_valid[s]           = 1'b0;
            req_data[s*DW +: DW]   = '0;
            req_last[s]            = 1'b0;
         end
      end
   endtask

   // One clock of model-driven traffic; entered and left at posedge+1.
   task automatic engine_cycle(input int ena_pct, input int rd_pct);
      logic [NR-1:0] acc;
      logic          ok;
      ena           = ($urandom_range(99) < ena_pct);
      fifo_rd_pulse = ($urandom_range(99) < rd_pct);
      drive_srcs();
      @(negedge clk);
      check("wr_valid", o_wr_valid, wr_pend && ena);
      if (wr_pend && ena) begin
         if (exp_stream.size() == 0) check("wr_extra", exp_stream.size(), 1);
         else                        check("wr_data", o_wr_data, exp_stream.pop_front());
      end
      check("level", o_level, lvl_m);
      check("abort_idle", o_abort, 1'b0);
      ok = ($countones(o_ready) <= 1) && ((o_ready == '0) || (ena && lvl_m < DEPTH));
      check("ready_legal", ok, 1'b1);
      acc = req_valid & o_ready;
      if (ena) begin
         if ((|acc) && !fifo_rd_pulse)                  lvl_m++;
         else if (!(|acc) && fifo_rd_pulse && lvl_m > 0) lvl_m--;
         wr_pend = |acc;
      end
      step();
      for (int s = 0; s < NR; s++) if (acc[s]) void'(srcq[s].pop_front());
   endtask

   task automatic run_until_done(input int ena_pct, input int rd_pct, input int budget);
      int n = 0;
      while ((exp_stream.size() > 0) && (n < budget)) begin
         engine_cycle(ena_pct, rd_pct);
         n++;
      end
      check("stream_drained", exp_stream.size(), 0);
   endtask

   // Random messages on all sources, expected order from message-level
   // round-robin starting after source NR-1.
   task automatic random_round();
      int            nmsg [NR];
      int            mlen [NR][3];
      logic [DW-1:0] mdat [NR][3][5];
      int            next_m [NR];
      int            last_src, remaining, s;
      do_reset();
      remaining = 0;
      for (int i = 0; i < NR; i++) begin
         nmsg[i] = $urandom_range(3, 1);
         next_m[i] = 0;
         remaining += nmsg[i];
         for (int m = 0; m < nmsg[i]; m++) begin
            mlen[i][m] = $urandom_range(5, 1);
            for (int b = 0; b < mlen[i][m]; b++) begin
               mdat[i][m][b] = DW'($urandom);
               add_beat(i, mdat[i][m][b], b == mlen[i][m] - 1);
            end
         end
      end
      last_src = NR - 1;
      while (remaining > 0) begin
         for (int k = 1; k <= NR; k++) begin
            s = (last_src + k) % NR;
            if (next_m[s] < nmsg[s]) begin
               for (int b = 0; b < mlen[s][next_m[s]]; b++) exp_stream.push_back(mdat[s][next_m[s]][b]);
               next_m[s]++;
               last_src = s;
               remaining--;
               break;
            end
         end
      end
      run_until_done(85, 40, 2000);
      repeat (5) engine_cycle(100, 0);
      check("rand_busy_end", o_busy, 1'b0);
   endtask

   initial begin
      // ---- Reset state and a simple two-byte message from source 1 ----
      use_b = 1'b0;
      do_reset();
      check("rst_ready", o_ready, 3'b000);
      check("rst_wr_valid", o_wr_valid, 1'b0);
      check("rst_wr_data", o_wr_data, 8'h00);
      check("rst_grant", o_grant, 2'd2);
      check("rst_busy", o_busy, 1'b0);
      check("rst_level", o_level, 4'd0);
      check("rst_abort", o_abort, 1'b0);
      add_beat(1, 8'h41, 1'b0); add_beat(1, 8'h42, 1'b1);
      exp_stream.push_back(8'h41); exp_stream.push_back(8'h42);
      run_until_done(100, 100, 50);
      check("ab_grant", o_grant, 2'd1);
      check("ab_busy", o_busy, 1'b0);

      // ---- Three concurrent sources, source 0 re-requests ----
      do_reset();
      add_beat(0, 8'h01, 1'b0); add_beat(0, 8'h02, 1'b1);
      add_beat(0, 8'h03, 1'b0); add_beat(0, 8'h04, 1'b1);
      add_beat(1, 8'h11, 1'b0); add_beat(1, 8'h12, 1'b1);
      add_beat(2, 8'h21, 1'b0); add_beat(2, 8'h22, 1'b1);
      foreach (exp_stream[i]) ;
      exp_stream = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h03, 8'h04};
      run_until_done(100, 100, 100);
      check("rr_grant", o_grant, 2'd0);

      // ---- Full FIFO: 12 bytes, no drain (timeout disabled instance) ----
      use_b = 1'b1;
      do_reset();
      for (int i = 0; i < 12; i++) add_beat(0, 8'hA0 + 8'(i), i == 11);
      for (int i = 0; i < 10; i++) exp_stream.push_back(8'hA0 + 8'(i));
      repeat (20) engine_cycle(100, 0);
      check("full_left", srcq[0].size(), 2);
      check("full_level", o_level, 4'd10);
      check("full_ready", o_ready, 3'b000);
      engine_cycle(100, 100);
      exp_stream.push_back(8'hAA);
      repeat (4) engine_cycle(100, 0);
      check("full_left2", srcq[0].size(), 1);
      check("full_level2", o_level, 4'd10);
      check("full_ready2", o_ready, 3'b000);
      exp_stream.push_back(8'hAB);
      run_until_done(100, 100, 100);

      // ---- Timeout abort on source 2, then source 0 is served ----
      use_b = 1'b0;
      do_reset();
      ena = 1'b1;
      req_valid = 3'b100; req_data[16 +: 8] = 8'h55; req_last = 3'b000;
      check("to_idle_ready", o_ready, 3'b000);
      step();
      check("to_grant2", o_grant, 2'd2);
      check("to_ready2", o_ready, 3'b100);
      step();
      check("to_wr55_v", o_wr_valid, 1'b1);
      check("to_wr55_d", o_wr_data, 8'h55);
      req_valid = 3'b001; req_data[0 +: 8] = 8'h66; req_last = 3'b001;
      for (int i = 0; i < 3; i++) begin
         step();
         check("to_no_abort", o_abort, 1'b0);
         check("to_busy", o_busy, 1'b1);
      end
      step();
      check("to_abort", o_abort, 1'b1);
      check("to_abort_idle", o_busy, 1'b0);
      check("to_abort_grant", o_grant, 2'd2);
      step();
      check("to_abort_end", o_abort, 1'b0);
      check("to_grant0", o_grant, 2'd0);
      check("to_ready0", o_ready, 3'b001);
      step();
      check("to_wr66_v", o_wr_valid, 1'b1);
      check("to_wr66_d", o_wr_data, 8'h66);
      check("to_level", o_level, 4'd2);
      req_valid = '0; req_last = '0;

      // ---- Enable freeze mid-message while the drain strobe toggles ----
      do_reset();
      for (int i = 0; i < 6; i++) begin
         add_beat(1, 8'h60 + 8'(i), i == 5);
         exp_stream.push_back(8'h60 + 8'(i));
      end
      repeat (3) engine_cycle(100, 0);
      check("frz_level_pre", o_level, 4'd2);
      for (int i = 0; i < 5; i++) engine_cycle(0, (i % 2 == 0) ? 100 : 0);
      check("frz_level_post", o_level, 4'd2);
      check("frz_left", srcq[1].size(), 4);
      run_until_done(100, 0, 100);

      // ---- Gap: two back-to-back single-byte messages from source 1 ----
      use_b = 1'b1;
      do_reset();
      ena = 1'b1;
      req_valid = 3'b010; req_data[8 +: 8] = 8'h31; req_last = 3'b010;
      step();
      check("gap_grant", o_grant, 2'd1);
      check("gap_ready", o_ready, 3'b010);
      step();
      req_data[8 +: 8] = 8'h32;
      check("gap_wr31_v", o_wr_valid, 1'b1);
      check("gap_wr31_d", o_wr_data, 8'h31);
      for (int i = 0; i < 3; i++) begin
         check("gap_busy", o_busy, 1'b1);
         check("gap_ready_low", o_ready, 3'b000);
         step();
      end
      check("gap_idle", o_busy, 1'b0);
      check("gap_idle_ready", o_ready, 3'b000);
      step();
      check("gap_regrant", o_ready, 3'b010);
      check("gap_regrant_busy", o_busy, 1'b1);
      step();
      check("gap_wr32_v", o_wr_valid, 1'b1);
      check("gap_wr32_d", o_wr_data, 8'h32);
      req_valid = '0; req_last = '0;

      // ---- Randomized traffic against the message-level model ----
      for (int r = 0; r < 4; r++) random_round();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
